alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Front end for the 8-bit ALU board design: turns one 8-switch bank and two push-buttons into the ALU's operand/select inputs (A, B, sel).
- Captures the ALU result and flags and holds them on the LEDs.
- Replaces direct switch wiring. The operator keys A, then B, then op, then reads the latched result.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  8  shared switch bank (asynchronous)
- btn_enter  in  1  enter button, active-high, asynchronous, bouncy
- btn_clear  in  1  clear button, active-high, asynchronous, bouncy
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_sel  out  3  registered op select to ALU
- alu_valid  out  1  one-cycle pulse, operands stable, in S_EXEC
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_carry, alu_zero, alu_neg, alu_ovf  in  1 each  ALU flags
- leds  out  8  display value
- led_carry, led_zero, led_neg, led_ovf  out  1 each  latched flags
- led_state  out  3  current state code

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state S_A.
  - Debounce counters and synchronizers are cleared.
  - Reset mid-operation discards any partial entry.
- Button path:
  - Each button passes through a 2-flop synchronizer, then the debouncer.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A rising edge of the debounced level gives a single-cycle press pulse. A held button gives exactly one pulse.
- States and led_state codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_CAP=4, S_SHOW=5.
  - S_A: on enter, alu_a<=sw, go to S_B.
  - S_B: on enter, alu_b<=sw, go to S_OP.
  - S_OP: on enter, alu_sel<=sw[2:0] (sw[7:3] ignored), go to S_EXEC.
  - S_EXEC: alu_valid=1 for this cycle only; unconditionally go to S_CAP next cycle.
  - S_CAP: on this edge, register alu_result into the result register and flags into led_*, go to S_SHOW.
  - S_SHOW: on enter, go to S_A. alu_a/alu_b/alu_sel are retained until overwritten.
- Latency: the enter pulse in S_OP is followed by alu_valid 1 cycle later, and the result is on the LEDs 3 cycles after the pulse.
- Display:
  - leds = live sw in S_A/S_B/S_OP.
  - leds = latched result in S_CAP/S_SHOW.
  - leds = 0 in S_EXEC.
  - Flag LEDs hold their last captured values until the next capture or clear.
- Clear:
  - A clear pulse in any state goes to S_A next cycle.
  - It zeroes alu_a, alu_b, alu_sel, the result register and flag LEDs.
  - Clear and enter pulses in the same cycle: clear wins, enter is ignored.
- Enter pulses in S_EXEC/S_CAP are ignored (not queued).

Optional Feature:
- Macro: ALU_LOADER_CHAIN_EN.
- Defined: enter in S_SHOW loads alu_a<=latched result and goes to S_B, chaining operations through the accumulator. Clear still returns to S_A with everything zeroed.
- Undefined: enter in S_SHOW goes to S_A as specified above. No chaining logic is generated.

Decomposition:
- Package alu_loader_pkg holds:
  - the state enum (3-bit, codes above);
  - the DATA_W=8 and SEL_W=3 constants.
- Sub-module btn_debounce (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES) is instantiated twice.
- The FSM and capture registers stay in alu_operand_loader.

Test Plan (DEBOUNCE_CYCLES=4; the bench models the ALU with sel=0 as add):
- Reset, then enter with sw=0x3C, enter with sw=0x05, enter with sw=0x00 -> alu_a=0x3C, alu_b=0x05, alu_sel=0; alu_valid high exactly 1 cycle; leds=0x41 in S_SHOW; all flags 0.
- A=0x80, B=0x80, sel=0 -> leds=0x00, led_carry=1, led_zero=1, led_ovf=1, led_neg=0.
- Enter button bounces 0/1 every cycle for 10 cycles, then holds high for 20 cycles -> exactly one state advance. A 3-cycle glitch produces no advance.
- Clear asserted while in S_OP with A=0x11, B=0x22 -> next cycle in S_A, alu_a=alu_b=alu_sel=0, flags 0.
- Clear and enter debounced pulses coincide in S_B -> state S_A, alu_b unchanged at 0.
- ALU_LOADER_CHAIN_EN defined: 0x10+0x01 shown, then enter, enter with B=0x02, enter with sel=0 -> alu_a=0x11, leds=0x13. rst_n dropped mid-S_CAP -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_loader_pkg.sv
// Shared types and widths for the ALU operand loader.
// Latency: n/a (types only). Backpressure: n/a.
// State codes are visible on led_state, so their encoding is fixed.
package alu_loader_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_CAP  = 3'd4,
        S_SHOW = 3'd5
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand/result bus between the loader (master) and the combinational ALU (slave).
// Latency: none; wires only. Backpressure: none, alu_valid is a one-cycle strobe.
// The ALU must settle alu_result/flags within the cycle after alu_valid.
interface alu_operand_loader_if;
    import alu_loader_pkg::*;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic              alu_valid;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;
    logic              alu_neg;
    logic              alu_ovf;

    modport master (
        output alu_a, alu_b, alu_sel, alu_valid,
        input  alu_result, alu_carry, alu_zero, alu_neg, alu_ovf
    );

    modport slave (
        input  alu_a, alu_b, alu_sel, alu_valid,
        output alu_result, alu_carry, alu_zero, alu_neg, alu_ovf
    );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES before the one-cycle press pulse.
// No backpressure: a held button yields exactly one pulse; bounces shorter than the window are dropped.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the window.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                press   <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU front end: enter steps A, B, op entry from the switch bank; clear zeroes everything (ALU_LOADER_CHAIN_EN feeds result back into A).
// Latency: alu_valid 1 cycle after the enter press in S_OP; result on leds 3 cycles after that press.
// No backpressure: enter presses in S_EXEC/S_CAP are dropped, clear overrides enter.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    sw,
    input  logic                 btn_enter,
    input  logic                 btn_clear,
    alu_operand_loader_if.master alu,
    output logic [DATA_W-1:0]    leds,
    output logic                 led_carry,
    output logic                 led_zero,
    output logic                 led_neg,
    output logic                 led_ovf,
    output logic [2:0]           led_state
);

    logic enter_p;
    logic clear_p;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_enter_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_enter),
        .press(enter_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_clear),
        .press(clear_p)
    );

    state_t            state_q;
    logic [DATA_W-1:0] sw_q;
    logic [DATA_W-1:0] result_q;
    flags_t            flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_A;
            sw_q          <= '0;
            result_q      <= '0;
            flags_q       <= '0;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            alu.alu_sel   <= '0;
            alu.alu_valid <= 1'b0;
        end else begin
            // Single registered sample of the switches feeds both capture and display.
            sw_q          <= sw;
            alu.alu_valid <= 1'b0;
            if (clear_p) begin
                state_q     <= S_A;
                result_q    <= '0;
                flags_q     <= '0;
                alu.alu_a   <= '0;
                alu.alu_b   <= '0;
                alu.alu_sel <= '0;
            end else begin
                unique case (state_q)
                    S_A: begin
                        if (enter_p) begin
                            alu.alu_a <= sw_q;
                            state_q   <= S_B;
                        end
                    end
                    S_B: begin
                        if (enter_p) begin
                            alu.alu_b <= sw_q;
                            state_q   <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (enter_p) begin
                            alu.alu_sel   <= sw_q[SEL_W-1:0];
                            alu.alu_valid <= 1'b1;
                            state_q       <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        state_q <= S_CAP;
                    end
                    S_CAP: begin
                        result_q      <= alu.alu_result;
                        flags_q.carry <= alu.alu_carry;
                        flags_q.zero  <= alu.alu_zero;
                        flags_q.neg   <= alu.alu_neg;
                        flags_q.ovf   <= alu.alu_ovf;
                        state_q       <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (enter_p) begin
`ifdef ALU_LOADER_CHAIN_EN
                            alu.alu_a <= result_q;
                            state_q   <= S_B;
`else
                            state_q   <= S_A;
`endif
                        end
                    end
                    default: begin
                        state_q <= S_A;
                    end
                endcase
            end
        end
    end

    always_comb begin
        leds = '0;
        unique case (state_q)
            S_A, S_B, S_OP: leds = sw_q;
            S_CAP, S_SHOW:  leds = result_q;
            default:        leds = '0;
        endcase
    end

    assign led_carry = flags_q.carry;
    assign led_zero  = flags_q.zero;
    assign led_neg   = flags_q.neg;
    assign led_ovf   = flags_q.ovf;
    assign led_state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader with a behavioural ALU and a press-level reference model.
// Latency: checks taken after each press settles. Backpressure: n/a.
// Build with ALU_LOADER_CHAIN_EN to exercise accumulator chaining.
module tb_alu_operand_loader;
    import alu_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] leds;
    logic       led_carry, led_zero, led_neg, led_ovf;
    logic [2:0] led_state;

    alu_operand_loader_if alu_bus();

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .alu      (alu_bus.master),
        .leds     (leds),
        .led_carry(led_carry),
        .led_zero (led_zero),
        .led_neg  (led_neg),
        .led_ovf  (led_ovf),
        .led_state(led_state)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, zero, neg, ovf, result}.
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = 9'd0;
        r = 8'd0;
        c = 1'b0;
        v = 1'b0;
        case (sel)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
            3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: r = b;
        endcase
        return {c, (r == 8'd0), r[7], v, r};
    endfunction

    always_comb begin
        {alu_bus.alu_carry, alu_bus.alu_zero, alu_bus.alu_neg, alu_bus.alu_ovf,
         alu_bus.alu_result} = alu_fn(alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_sel);
    end

    int checks = 0;
    int errors = 0;

    // Reference model at the level of whole presses.
    int         m_state = 0;
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_res = 8'h00;
    logic [3:0] m_flags = 4'h0;

    int         cyc_n = 0;
    int         valid_cnt = 0;
    int         exec_cyc = 0;
    int         show_cyc = 0;
    logic       valid_at_exec = 1'b0;
    logic [2:0] prev_state = 3'd0;

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (alu_bus.alu_valid === 1'b1) valid_cnt = valid_cnt + 1;
        if (led_state == 3'd3 && prev_state != 3'd3) begin
            exec_cyc      = cyc_n;
            valid_at_exec = alu_bus.alu_valid;
        end
        if (led_state == 3'd5 && prev_state != 3'd5) show_cyc = cyc_n;
        prev_state = led_state;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_state = 0; m_a = 8'h00; m_b = 8'h00; m_sel = 3'd0; m_res = 8'h00; m_flags = 4'h0;
    endtask

    task automatic model_enter();
        case (m_state)
            0: begin m_a = sw; m_state = 1; end
            1: begin m_b = sw; m_state = 2; end
            2: begin
                m_sel = sw[2:0];
                {m_flags, m_res} = alu_fn(m_a, m_b, m_sel);
                m_state = 5;
            end
            5: begin
`ifdef ALU_LOADER_CHAIN_EN
                m_a = m_res; m_state = 1;
`else
                m_state = 0;
`endif
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic press(input logic ent, input logic clr);
        btn_enter = ent;
        btn_clear = clr;
        cyc(10);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cyc(10);
        if (clr) model_clear();
        else if (ent) model_enter();
    endtask

    task automatic enter_with(input logic [7:0] v);
        sw = v;
        cyc(2);
        press(1'b1, 1'b0);
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_leds;
        exp_leds = (m_state <= 2) ? sw : ((m_state == 5) ? m_res : 8'h00);
        chk({tag, "/state"}, led_state, m_state);
        chk({tag, "/a"}, alu_bus.alu_a, m_a);
        chk({tag, "/b"}, alu_bus.alu_b, m_b);
        chk({tag, "/sel"}, alu_bus.alu_sel, m_sel);
        chk({tag, "/leds"}, leds, exp_leds);
        chk({tag, "/flags"}, {led_carry, led_zero, led_neg, led_ovf}, m_flags);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/state"}, led_state, 0);
        chk({tag, "/a"}, alu_bus.alu_a, 0);
        chk({tag, "/b"}, alu_bus.alu_b, 0);
        chk({tag, "/sel"}, alu_bus.alu_sel, 0);
        chk({tag, "/valid"}, alu_bus.alu_valid, 0);
        chk({tag, "/leds"}, leds, 0);
        chk({tag, "/flags"}, {led_carry, led_zero, led_neg, led_ovf}, 0);
    endtask

    initial begin
        int  v0;
        int  roll;
        bit  found;

        // Reset with switches non-zero: leds must still read 0.
        sw = 8'hA5;
        cyc(3);
        check_zero("reset");
        rst_n = 1'b1;
        cyc(3);

        // 0x3C + 0x05 with latency and single-cycle valid.
        enter_with(8'h3C);
        enter_with(8'h05);
        v0 = valid_cnt;
        enter_with(8'h00);
        chk("add/valid_cycles", valid_cnt - v0, 1);
        chk("add/valid_in_exec", valid_at_exec, 1);
        chk("add/exec_to_show", show_cyc - exec_cyc, 2);
        chk("add/leds_const", leds, 8'h41);
        check_model("add");
        enter_with(8'hEE);
        check_model("show_enter");
        press(1'b0, 1'b1);
        check_model("clear1");

        // 0x80 + 0x80: carry, zero and overflow, not negative.
        enter_with(8'h80);
        enter_with(8'h80);
        enter_with(8'h00);
        chk("ovf/leds", leds, 8'h00);
        chk("ovf/flags_cznv", {led_carry, led_zero, led_neg, led_ovf}, 4'b1101);
        check_model("ovf");
        press(1'b0, 1'b1);
        check_model("clear2");

        // Bouncy press gives one advance; short glitch gives none.
        sw = 8'h5A;
        cyc(2);
        for (int i = 0; i < 10; i++) begin
            btn_enter = (i % 2 == 0);
            cyc(1);
        end
        btn_enter = 1'b1;
        cyc(20);
        btn_enter = 1'b0;
        cyc(10);
        model_enter();
        check_model("bounce");
        btn_enter = 1'b1;
        cyc(3);
        btn_enter = 1'b0;
        cyc(10);
        check_model("glitch");

        // Clear from S_OP.
        press(1'b0, 1'b1);
        enter_with(8'h11);
        enter_with(8'h22);
        chk("op/state", led_state, 3'd2);
        press(1'b0, 1'b1);
        check_model("clear_op");

        // Coincident clear and enter in S_B.
        enter_with(8'h33);
        sw = 8'h77;
        cyc(2);
        press(1'b1, 1'b1);
        chk("both/b", alu_bus.alu_b, 8'h00);
        check_model("both");

        // Random walk of enters, clears and glitches.
        for (int i = 0; i < 30; i++) begin
            roll = $urandom_range(0, 99);
            sw = 8'($urandom);
            cyc(2);
            if (roll < 12) begin
                press(1'b0, 1'b1);
            end else if (roll < 20) begin
                btn_enter = 1'b1;
                cyc(3);
                btn_enter = 1'b0;
                cyc(10);
            end else begin
                press(1'b1, 1'b0);
            end
            check_model($sformatf("rand%0d", i));
        end

`ifdef ALU_LOADER_CHAIN_EN
        press(1'b0, 1'b1);
        enter_with(8'h10);
        enter_with(8'h01);
        enter_with(8'h00);
        chk("chain/first", leds, 8'h11);
        enter_with(8'h00);
        chk("chain/a", alu_bus.alu_a, 8'h11);
        enter_with(8'h02);
        enter_with(8'h00);
        chk("chain/a_kept", alu_bus.alu_a, 8'h11);
        chk("chain/leds", leds, 8'h13);
        check_model("chain");
`endif

        // Async reset while in S_CAP.
        press(1'b0, 1'b1);
        enter_with(8'h21);
        enter_with(8'h42);
        sw = 8'hFF;
        cyc(2);
        btn_enter = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (led_state == 3'd4) found = 1'b1;
        end
        chk("cap/reached", found, 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_cap");
        btn_enter = 1'b0;
        cyc(10);
        rst_n = 1'b1;
        cyc(3);
        model_clear();
        check_model("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
